// File: rtl/mbscore_fetch_unit_pkg.sv
// Shared constants for the MBScore fetch stage: FSM state encoding and reset PC.
package mbscore_fetch_unit_pkg;

  // Fetch FSM states, 2-bit encoding shared with the rest of the core.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } fetch_state_e;

  // Default PC after reset; must be word aligned.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Byte distance between consecutive instructions.
  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/mbscore_pc_reg.sv
// PC register with +4 incrementer and a pending-redirect slot.
// Redirects seen while idle load the PC straight away; redirects seen during a
// fetch are parked and applied when the fetch retires (last one wins).
module mbscore_pc_reg
  import mbscore_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idle_i,
  input  logic                  advance_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_inc_o
);

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0] target;

  // Targets are forced to word alignment on capture; the add wraps naturally.
  assign target   = redirect_pc_i & ALIGN_MASK;
  assign pc_inc_o = pc_q + STEP;
  assign pc_o     = pc_q;

  // Next PC selection: retire (redirect > pending > +4), idle load, or park.
  always_comb begin
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    if (advance_i) begin
      if (redirect_valid_i) begin
        pc_d = target;
      end else if (pend_valid_q) begin
        pc_d = pend_pc_q;
      end else begin
        pc_d = pc_inc_o;
      end
      pend_valid_d = 1'b0;
    end else if (redirect_valid_i) begin
      if (idle_i) begin
        pc_d = target;
      end else begin
        pend_valid_d = 1'b1;
        pend_pc_d    = target;
      end
    end
  end

  // PC and pending-redirect state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
    end
  end

endmodule

// File: rtl/mbscore_fetch_unit.sv
// MBScore instruction-fetch stage: fetch FSM, instruction register and link value.
// Reads imem over req/gnt/rvalid, latches the word into IR and advances the PC.
module mbscore_fetch_unit
  import mbscore_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_start,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  fetch_done,
  output logic                  busy
);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [ADDR_WIDTH-1:0] pc_inc;

  mbscore_pc_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk              (clk),
    .rst              (rst),
    .idle_i           (state_q == S_IDLE),
    .advance_i        (state_q == S_DONE),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .pc_o             (pc),
    .pc_inc_o         (pc_inc)
  );

  // The request address is the current PC, which only moves when the fetch retires.
  assign imem_addr = pc;
  assign inst      = inst_q;
  assign pc_plus4  = pc_plus4_q;

  // Next-state logic, IR capture and handshake outputs.
  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    pc_plus4_d = pc_plus4_q;
    imem_req   = 1'b0;
    busy       = 1'b0;
    fetch_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fetch_start && !halt) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        if (imem_gnt) begin
          if (imem_rvalid) begin
            inst_d     = imem_rdata;
            pc_plus4_d = pc_inc;
            state_d    = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (imem_rvalid) begin
          inst_d     = imem_rdata;
          pc_plus4_d = pc_inc;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        fetch_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, IR and link register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      inst_q     <= '0;
      pc_plus4_q <= RESET_PC + ADDR_WIDTH'(PC_STEP);
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

endmodule
